// File: rtl/nco_multichannel.sv
// rtl/nco_multichannel.sv - time-multiplexed multichannel NCO with quarter-wave sine/cosine table
//
// Purpose:
//   NUM_CH independent numerically controlled oscillators that share one
//   phase adder and one quarter-wave table. Each issue cycle serves one
//   channel. Channels are served round-robin by a shared channel counter.
//   Every sample emerges exactly four cycles after it was issued.
//
// Ports:
//   clk         clock, rising edge
//   arst        asynchronous active-high reset
//   en          issue one sample for the current channel this cycle
//   phase_sync  clear all accumulators and the channel counter (wins over en)
//   cfg_we      configuration write strobe
//   cfg_sel     0 = tuning word (ftw), 1 = phase offset (poff)
//   cfg_ch      channel targeted by the configuration write
//   cfg_data    configuration value
//   out_valid   one-cycle flag: out_ch/sin_out/cos_out hold a new sample
//   out_ch      channel of the current output sample
//   sin_out     signed sine sample
//   cos_out     signed cosine sample

module nco_multichannel #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int PHASE_WIDTH = 32,
    parameter  int QLUT_DEPTH  = 11,
    parameter  int NUM_CH      = 4,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en,
    input  logic                         phase_sync,
    input  logic                         cfg_we,
    input  logic                         cfg_sel,
    input  logic [CHW-1:0]               cfg_ch,
    input  logic [PHASE_WIDTH-1:0]       cfg_data,
    output logic                         out_valid,
    output logic [CHW-1:0]               out_ch,
    output logic signed [DATA_WIDTH-1:0] sin_out,
    output logic signed [DATA_WIDTH-1:0] cos_out
);

    localparam int  FINE_W    = QLUT_DEPTH - 2;
    localparam int  QLUT_SIZE = 1 << FINE_W;
    localparam real AMP       = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
    localparam real FULL_WAVE = 2.0 ** QLUT_DEPTH;
    localparam real TWO_PI    = 6.283185307179586;

    // ------------------------------------------------------------------
    // Quarter-wave table. Entries are sampled at the middle of each phase
    // bin (i + 0.5), which makes the table symmetric under index mirroring
    // so the fold below needs only an XOR, never an add-one. All entries
    // are non-negative and at most AMP, so negation can never overflow.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] qlut [QLUT_SIZE];

    for (genvar i = 0; i < QLUT_SIZE; i++) begin : g_qlut
        localparam int ENTRY =
            $rtoi(AMP * $sin(TWO_PI * (real'(i) + 0.5) / FULL_WAVE) + 0.5);
        assign qlut[i] = DATA_WIDTH'(ENTRY);
    end

    // ------------------------------------------------------------------
    // Per-channel state and the shared channel counter
    // ------------------------------------------------------------------
    logic [PHASE_WIDTH-1:0] acc  [NUM_CH];
    logic [PHASE_WIDTH-1:0] ftw  [NUM_CH];
    logic [PHASE_WIDTH-1:0] poff [NUM_CH];
    logic [CHW-1:0]         ch_cnt;

    logic issue;
    logic cfg_hit;

    // phase_sync suppresses the sample that en would otherwise issue.
    assign issue   = en & ~phase_sync;
    // Writes aimed past the last channel are dropped.
    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ch_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else if (phase_sync) begin
            ch_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else if (en) begin
            acc[ch_cnt] <= acc[ch_cnt] + ftw[ch_cnt];
            ch_cnt      <= (ch_cnt == CHW'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
        end
    end

    // Configuration registers. A sample issued in the same cycle reads the
    // pre-edge value, so a new word takes effect from the next issue on.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ftw[c]  <= '0;
                poff[c] <= '0;
            end
        end else if (cfg_hit) begin
            if (cfg_sel) begin
                poff[cfg_ch] <= cfg_data;
            end else begin
                ftw[cfg_ch] <= cfg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0 (issue cycle): phase add and truncation to the table phase.
    // The sum wraps modulo 2^PHASE_WIDTH; only the top QLUT_DEPTH bits are
    // kept, with no rounding or dither.
    // ------------------------------------------------------------------
    logic [QLUT_DEPTH-1:0] s0_t;

    assign s0_t = QLUT_DEPTH'((acc[ch_cnt] + poff[ch_cnt]) >> (PHASE_WIDTH - QLUT_DEPTH));

    logic                  s1_valid;
    logic [CHW-1:0]        s1_ch;
    logic [QLUT_DEPTH-1:0] s1_t;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_t     <= '0;
        end else begin
            s1_valid <= issue;
            s1_ch    <= ch_cnt;
            s1_t     <= s0_t;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: quadrant fold. Odd quadrants walk the quarter table
    // backwards for sine; cosine is the same fold shifted by one quadrant.
    // ------------------------------------------------------------------
    logic [1:0]        s1_q;
    logic [FINE_W-1:0] s1_f;

    assign s1_q = s1_t[QLUT_DEPTH-1 -: 2];
    assign s1_f = s1_t[FINE_W-1:0];

    logic              s2_valid;
    logic [CHW-1:0]    s2_ch;
    logic [FINE_W-1:0] s2_sin_addr;
    logic [FINE_W-1:0] s2_cos_addr;
    logic              s2_sin_neg;
    logic              s2_cos_neg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_valid    <= 1'b0;
            s2_ch       <= '0;
            s2_sin_addr <= '0;
            s2_cos_addr <= '0;
            s2_sin_neg  <= 1'b0;
            s2_cos_neg  <= 1'b0;
        end else begin
            s2_valid    <= s1_valid;
            s2_ch       <= s1_ch;
            s2_sin_addr <= s1_f ^ {FINE_W{s1_q[0]}};
            s2_cos_addr <= s1_f ^ {FINE_W{~s1_q[0]}};
            // Sine is negative in the lower half-plane (quadrants 2, 3);
            // cosine is negative in the left half-plane (quadrants 1, 2).
            s2_sin_neg  <= s1_q[1];
            s2_cos_neg  <= s1_q[1] ^ s1_q[0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered table read (two read ports on one ROM)
    // ------------------------------------------------------------------
    logic                  s3_valid;
    logic [CHW-1:0]        s3_ch;
    logic [DATA_WIDTH-1:0] s3_sin_mag;
    logic [DATA_WIDTH-1:0] s3_cos_mag;
    logic                  s3_sin_neg;
    logic                  s3_cos_neg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s3_valid   <= 1'b0;
            s3_ch      <= '0;
            s3_sin_mag <= '0;
            s3_cos_mag <= '0;
            s3_sin_neg <= 1'b0;
            s3_cos_neg <= 1'b0;
        end else begin
            s3_valid   <= s2_valid;
            s3_ch      <= s2_ch;
            s3_sin_mag <= qlut[s2_sin_addr];
            s3_cos_mag <= qlut[s2_cos_addr];
            s3_sin_neg <= s2_sin_neg;
            s3_cos_neg <= s2_cos_neg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sign application into the output registers. Data outputs
    // only load with a valid sample so they hold between samples.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            sin_out   <= '0;
            cos_out   <= '0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_ch  <= s3_ch;
                sin_out <= s3_sin_neg ? -s3_sin_mag : s3_sin_mag;
                cos_out <= s3_cos_neg ? -s3_cos_mag : s3_cos_mag;
            end
        end
    end

endmodule

// File: tb/tb_nco_multichannel.sv
// tb/tb_nco_multichannel.sv - self-checking bench for nco_multichannel
module tb_nco_multichannel;

    localparam real PI = 3.14159265358979323846;

    logic               clk        = 1'b0;
    logic               arst       = 1'b1;
    logic               en         = 1'b0;
    logic               phase_sync = 1'b0;
    logic               cfg_we     = 1'b0;
    logic               cfg_sel    = 1'b0;
    logic [1:0]         cfg_ch     = '0;
    logic [31:0]        cfg_data   = '0;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;

    nco_multichannel #(
        .DATA_WIDTH (16),
        .PHASE_WIDTH(32),
        .QLUT_DEPTH (11),
        .NUM_CH     (4)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .phase_sync(phase_sync),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .sin_out   (sin_out),
        .cos_out   (cos_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard of expected output samples
    typedef struct {
        int due;
        int ch;
        int s;
        int c;
    } sb_t;
    sb_t sb[$];

    // Reference oscillator state
    logic [31:0] m_acc  [4];
    logic [31:0] m_ftw  [4];
    logic [31:0] m_poff [4];
    int          m_ch;

    // When set, the next issued sample expects these values instead of the model
    bit ovr = 1'b0;
    int ovr_s;
    int ovr_c;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Ideal sine/cosine at the centre of the truncated phase bin
    function automatic void model_sc(input logic [31:0] p, output int s, output int c);
        int  t;
        real a;
        t = int'(p[31:21]);
        a = 2.0 * PI * (real'(t) + 0.5) / 2048.0;
        s = rnd(32767.0 * $sin(a));
        c = rnd(32767.0 * $cos(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_acc[i]  = '0;
            m_ftw[i]  = '0;
            m_poff[i] = '0;
        end
        m_ch = 0;
    endtask

    // One clock cycle of stimulus, with the reference model stepped alongside
    task automatic drive(input logic e, input logic s, input logic w, input logic sel,
                         input int ch, input logic [31:0] d);
        sb_t         item;
        logic [31:0] p;
        @(negedge clk);
        en         = e;
        phase_sync = s;
        cfg_we     = w;
        cfg_sel    = sel;
        cfg_ch     = 2'(ch);
        cfg_data   = d;
        if (s) begin
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
            m_ch = 0;
        end else if (e) begin
            p        = m_acc[m_ch] + m_poff[m_ch];
            item.due = cyc + 4;
            item.ch  = m_ch;
            model_sc(p, item.s, item.c);
            if (ovr) begin
                item.s = ovr_s;
                item.c = ovr_c;
            end
            sb.push_back(item);
            m_acc[m_ch] = m_acc[m_ch] + m_ftw[m_ch];
            m_ch        = (m_ch + 1) % 4;
        end
        if (w) begin
            if (sel) m_poff[ch] = d;
            else     m_ftw[ch]  = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic drain(input string name);
        idle(6);
        check(name, sb.size(), 0);
    endtask

    task automatic set_cfg(input logic sel, input int ch, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b1, sel, ch, d);
    endtask

    // Output monitor: pops the scoreboard on valid, checks hold otherwise
    int last_ch = 0;
    int last_s  = 0;
    int last_c  = 0;

    initial forever begin
        sb_t e;
        @(negedge clk);
        if (arst) begin
            last_ch = 0;
            last_s  = 0;
            last_c  = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got out_valid=1 ch=%0d, expected no sample (cycle %0d)",
                         out_ch, cyc);
            end else begin
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("out_ch", out_ch, e.ch);
                check("sin_out", sin_out, e.s);
                check("cos_out", cos_out, e.c);
            end
            last_ch = int'(out_ch);
            last_s  = int'(sin_out);
            last_c  = int'(cos_out);
        end else begin
            check("hold_ch", out_ch, last_ch);
            check("hold_sin", sin_out, last_s);
            check("hold_cos", cos_out, last_c);
        end
    end

    // Single-phase table vectors: phase set through ch0 POFF with FTW=0
    typedef struct {
        logic [31:0] phase;
        int          s;
        int          c;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0000,     50,  32767};
        vecs[1] = '{32'h4000_0000,  32767,    -50};
        vecs[2] = '{32'h8000_0000,    -50, -32767};
        vecs[3] = '{32'hC000_0000, -32767,     50};
        vecs[4] = '{32'hFFFF_FFFF,    -50,  32767};
        vecs[5] = '{32'h0020_0000,    151,  32767};
        vecs[6] = '{32'h001F_FFFF,     50,  32767};
        vecs[7] = '{32'h3FFF_FFFF,  32767,     50};

        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ch", out_ch, 0);
        check("rst_sin", sin_out, 0);
        check("rst_cos", cos_out, 0);
        #2 arst = 1'b0;

        // Table vectors: poff write with phase_sync in one cycle, issue the next
        foreach (vecs[i]) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 0, vecs[i].phase);
            ovr   = 1'b1;
            ovr_s = vecs[i].s;
            ovr_c = vecs[i].c;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
            ovr = 1'b0;
        end
        drain("drain_vectors");
        set_cfg(1'b1, 0, 32'd0);

        // Quarter-turn tuning on every channel, continuous issue
        for (int c = 0; c < 4; c++) set_cfg(1'b0, c, 32'h4000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        repeat (16) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_quarter");

        // Four distinct channel configurations
        set_cfg(1'b0, 0, 32'h0000_0000);
        set_cfg(1'b0, 1, 32'h4000_0000);
        set_cfg(1'b0, 2, 32'h8000_0000);
        set_cfg(1'b0, 3, 32'h0000_0000);
        set_cfg(1'b1, 3, 32'h4000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        repeat (16) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_four_ch");

        // Wrapping tuning word, plus a same-cycle FTW write while its channel issues
        set_cfg(1'b0, 1, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h1234_5678);
        repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_wrap");

        // en toggling 1,0,1,0
        for (int i = 0; i < 12; i++) drive(1'(~i[0]), 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_toggle");

        // phase_sync mid-stream with en held high
        set_cfg(1'b1, 0, 32'h2000_0000);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 32'd0);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_sync");

        // Random traffic: en, configuration writes, occasional phase_sync
        for (int i = 0; i < 300; i++) begin
            drive(1'(($urandom % 4) != 0), 1'(($urandom % 23) == 0), 1'(($urandom % 5) == 0),
                  1'($urandom % 2), int'($urandom % 4), $urandom);
        end
        drain("drain_random");

        // Asynchronous reset between edges with samples in flight
        for (int c = 0; c < 4; c++) set_cfg(1'b0, c, 32'h1357_9BDF + 32'(c));
        repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        #2;
        en     = 1'b0;
        cfg_we = 1'b0;
        arst   = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ch", out_ch, 0);
        check("arst_sin", sin_out, 0);
        check("arst_cos", cos_out, 0);
        sb.delete();
        model_clear();
        @(negedge clk);
        #2 arst = 1'b0;
        repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        drain("drain_after_arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL timeout: got no completion by cycle %0d, expected finish", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
